// File: rtl/r_chunk_read_sequencer_if.sv
// Streaming r-vector bus between memoryR / main_alu (master side) and the
// r_chunk_read_sequencer (slave side). Clock and reset stay plain ports.
interface r_chunk_read_sequencer_if #(
  parameter int element_width             = 32,
  parameter int no_of_units               = 8,
  parameter int memory_read_address_width = 20
);
  localparam int dw = element_width * no_of_units;
  localparam int aw = memory_read_address_width;

  logic          start;
  logic          read_again;
  logic          snapshot_req;
  logic [dw-1:0] memoryR_output;
  logic [aw-1:0] memoryR_read_address;
  logic [dw-1:0] chunk_data;
  logic          chunk_valid;
  logic          chunk_last;
  logic          memoryRprev_we;
  logic [aw-1:0] rkold_write_address;
  logic          busy;
  logic          pass_done;

  modport master (
    output start, read_again, snapshot_req, memoryR_output,
    input  memoryR_read_address, chunk_data, chunk_valid, chunk_last,
           memoryRprev_we, rkold_write_address, busy, pass_done
  );

  modport slave (
    input  start, read_again, snapshot_req, memoryR_output,
    output memoryR_read_address, chunk_data, chunk_valid, chunk_last,
           memoryRprev_we, rkold_write_address, busy, pass_done
  );
endinterface

// File: rtl/r_chunk_read_sequencer.sv
// r_chunk_read_sequencer: serves the ALU one no_of_units-wide chunk of r per
// read_again request, and on snapshot_req streams all of r into rKold_prev at
// one chunk per cycle. Every output is registered.
// Optional feature macro RSEQ_ZERO_PAD_EN: lanes of the final chunk that lie
// beyond the vector length are forced to zero, and snapshot write data is
// exported on chunk_data (trailing its write strobe by one cycle).
module r_chunk_read_sequencer #(
  parameter int          element_width                   = 32,
  parameter int          no_of_units                     = 8,
  parameter int          number_of_clusters              = 40,
  parameter int          number_of_equations_per_cluster = 19,
  parameter int          memory_read_address_width       = 20,
  parameter int unsigned base_address                    = 0
) (
  input logic                     clk,
  input logic                     reset,
  r_chunk_read_sequencer_if.slave bus
);
  localparam int dw         = element_width * no_of_units;
  localparam int aw         = memory_read_address_width;
  localparam int vec_len    = number_of_clusters * number_of_equations_per_cluster;
  localparam int num_chunks = (vec_len + no_of_units - 1) / no_of_units;
  localparam int cnt_w      = (num_chunks > 1) ? $clog2(num_chunks) : 1;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(num_chunks - 1);

`ifdef RSEQ_ZERO_PAD_EN
  // Keep only the lanes of the final chunk that hold real vector elements.
  function automatic logic [dw-1:0] build_last_mask();
    logic [dw-1:0] m;
    m = '0;
    for (int k = 0; k < no_of_units; k++)
      if ((num_chunks - 1) * no_of_units + k < vec_len)
        m[k*element_width +: element_width] = '1;
    return m;
  endfunction
  localparam logic [dw-1:0] last_mask = build_last_mask();
`endif

  typedef enum logic [2:0] {IDLE, FETCH, PRESENT, WAIT, SNAP, DONE} state_e;

  state_e         state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic           pending_q, pending_d;
  logic [aw-1:0]  addr_q, addr_d;
  logic [dw-1:0]  chunk_data_q, chunk_data_d;
  logic           chunk_valid_q, chunk_valid_d;
  logic           chunk_last_q, chunk_last_d;
  logic           we_q, we_d;
  logic [aw-1:0]  wr_addr_q, wr_addr_d;
  logic           busy_q;
  logic           pass_done_q, pass_done_d;
  logic           load_addr;

  // Next-state, counter, address and registered-output computation.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    pending_d     = pending_q;
    addr_d        = addr_q;
    chunk_data_d  = chunk_data_q;
    chunk_valid_d = 1'b0;
    chunk_last_d  = 1'b0;
    we_d          = 1'b0;
    wr_addr_d     = wr_addr_q;
    pass_done_d   = 1'b0;
    load_addr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A snapshot takes priority; a start arriving with it is dropped.
        if (bus.snapshot_req) begin
          state_d   = SNAP;
          cnt_d     = '0;
          load_addr = 1'b1;
        end else if (bus.start) begin
          state_d   = FETCH;
          cnt_d     = '0;
          pending_d = 1'b0;
          load_addr = 1'b1;
        end
      end
      FETCH: begin
        if (bus.read_again) pending_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (bus.read_again) pending_d = 1'b1;
`ifdef RSEQ_ZERO_PAD_EN
        chunk_data_d = (cnt_q == last_cnt) ? (bus.memoryR_output & last_mask)
                                           : bus.memoryR_output;
`else
        chunk_data_d = bus.memoryR_output;
`endif
        chunk_valid_d = 1'b1;
        if (cnt_q == last_cnt) begin
          chunk_last_d = 1'b1;
          state_d      = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.read_again || pending_q) begin
          cnt_d     = cnt_q + 1'b1;
          pending_d = 1'b0;
          load_addr = 1'b1;
          state_d   = FETCH;
        end
      end
      SNAP: begin
        // The read issued now returns next cycle, when the strobe goes out.
        we_d      = 1'b1;
        wr_addr_d = aw'(cnt_q);
        if (cnt_q == last_cnt) begin
          state_d = DONE;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          load_addr = 1'b1;
        end
      end
      DONE: begin
        pass_done_d = 1'b1;
        pending_d   = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef RSEQ_ZERO_PAD_EN
    // Export the snapshot data arriving alongside each write strobe.
    if (we_q)
      chunk_data_d = (wr_addr_q == aw'(last_cnt)) ? (bus.memoryR_output & last_mask)
                                                  : bus.memoryR_output;
`endif

    if (load_addr) addr_d = aw'(base_address) + aw'(cnt_d);
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      addr_q        <= '0;
      // NOTE: the wide data register is cleared too, because all outputs must read 0 in reset.
      chunk_data_q  <= '0;
      chunk_valid_q <= 1'b0;
      chunk_last_q  <= 1'b0;
      we_q          <= 1'b0;
      wr_addr_q     <= '0;
      busy_q        <= 1'b0;
      pass_done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      addr_q        <= addr_d;
      chunk_data_q  <= chunk_data_d;
      chunk_valid_q <= chunk_valid_d;
      chunk_last_q  <= chunk_last_d;
      we_q          <= we_d;
      wr_addr_q     <= wr_addr_d;
      busy_q        <= (state_d != IDLE);
      pass_done_q   <= pass_done_d;
    end
  end

  assign bus.memoryR_read_address = addr_q;
  assign bus.chunk_data           = chunk_data_q;
  assign bus.chunk_valid          = chunk_valid_q;
  assign bus.chunk_last           = chunk_last_q;
  assign bus.memoryRprev_we       = we_q;
  assign bus.rkold_write_address  = wr_addr_q;
  assign bus.busy                 = busy_q;
  assign bus.pass_done            = pass_done_q;
endmodule
